// File: rtl/cabac_ctx_bank.sv
// CABAC context-variable bank: slope/offset initialisation from an external initValue table,
// combinational read port, write-back port, optional WPP snapshot when CABAC_CTX_SYNC_EN is defined.
module cabac_ctx_bank #(
  parameter int CTX_NUM = 36,
  parameter int TAB_AW  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_init_start,
  input  logic [5:0]        i_SliceQpY,
  input  logic [1:0]        i_slice_type,
  input  logic              i_cabac_init_present_flag,
  input  logic              i_cabac_init_flag,
  output logic [TAB_AW-1:0] o_init_tab_addr,
  input  logic [7:0]        i_init_tab_value,
  output logic              o_init_done,
  output logic              o_busy,
  input  logic [7:0]        i_rd_idx,
  output logic [5:0]        o_pStateIdx,
  output logic              o_valMps,
  input  logic              i_upd_en,
  input  logic [7:0]        i_upd_idx,
  input  logic [5:0]        i_upd_pStateIdx,
  input  logic              i_upd_valMps,
  input  logic              i_sync_save,
  input  logic              i_sync_restore,
  output logic              o_sync_valid
);

  localparam int                IDX_W     = (CTX_NUM > 1) ? $clog2(CTX_NUM) : 1;
  localparam logic [IDX_W-1:0]  LAST_K    = IDX_W'(CTX_NUM - 1);
  localparam logic [TAB_AW-1:0] CTX_NUM_A = TAB_AW'(CTX_NUM);
  localparam logic [8:0]        CTX_NUM_9 = 9'(CTX_NUM);
  localparam logic [1:0]        SLICE_I   = 2'd2;

  logic                busy_r, done_r, iss_act_r, v1_r, v2_r;
  logic [IDX_W-1:0]    iss_k_r, k1_r, k2_r;
  logic [TAB_AW-1:0]   addr_r, base_s;
  logic [5:0]          qp_r, qp_clip_s;
  logic signed [7:0]   m_s, n_s, n_r;
  logic signed [13:0]  prod_s, prod_r;
  logic signed [9:0]   sum_s;
  logic [6:0]          pre_s;
  logic [5:0]          init_ps_s;
  logic                init_mps_s, last_wr_s, upd_ok_s, rd_ok_s;
  logic [6:0]          bank_r [CTX_NUM];

  // Table base for the requested initType and the QP clipped to 0..51.
  always_comb begin
    base_s = {TAB_AW{1'b0}};
    if (i_slice_type == SLICE_I) begin
      base_s = {TAB_AW{1'b0}};
    end else if (i_cabac_init_present_flag && i_cabac_init_flag) begin
      base_s = CTX_NUM_A << 1;
    end else begin
      base_s = CTX_NUM_A;
    end
    qp_clip_s = (i_SliceQpY > 6'd51) ? 6'd51 : i_SliceQpY;
  end

  // Slope/offset derivation: stage 2 from the table value, stage 3 from registered product.
  always_comb begin
    m_s    = $signed({4'b0000, i_init_tab_value[7:4]}) * 8'sd5 - 8'sd45;
    n_s    = $signed({1'b0, i_init_tab_value[3:0], 3'b000}) - 8'sd16;
    prod_s = $signed({{6{m_s[7]}}, m_s}) * $signed({8'b0000_0000, qp_r});
    sum_s  = $signed(prod_r[13:4]) + $signed({{2{n_r[7]}}, n_r});
    if (sum_s < 10'sd1) begin
      pre_s = 7'd1;
    end else if (sum_s > 10'sd126) begin
      pre_s = 7'd126;
    end else begin
      pre_s = sum_s[6:0];
    end
    init_mps_s = (pre_s > 7'd63);
    init_ps_s  = init_mps_s ? 6'(pre_s - 7'd64) : 6'(7'd63 - pre_s);
    last_wr_s  = v2_r && (k2_r == LAST_K);
    upd_ok_s   = i_upd_en && !busy_r && ({1'b0, i_upd_idx} < CTX_NUM_9);
    rd_ok_s    = ({1'b0, i_rd_idx} < CTX_NUM_9);
  end

  // Init sequencing: address issue, table-value stage and arithmetic stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      iss_act_r <= 1'b0;
      iss_k_r   <= {IDX_W{1'b0}};
      addr_r    <= {TAB_AW{1'b0}};
      qp_r      <= 6'd0;
      v1_r      <= 1'b0;
      k1_r      <= {IDX_W{1'b0}};
      v2_r      <= 1'b0;
      k2_r      <= {IDX_W{1'b0}};
      n_r       <= 8'sd0;
      prod_r    <= 14'sd0;
    end else if (i_init_start) begin
      busy_r    <= 1'b1;
      done_r    <= 1'b0;
      iss_act_r <= 1'b1;
      iss_k_r   <= {IDX_W{1'b0}};
      addr_r    <= base_s;
      qp_r      <= qp_clip_s;
      v1_r      <= 1'b0;
      v2_r      <= 1'b0;
    end else begin
      v1_r   <= iss_act_r;
      k1_r   <= iss_k_r;
      v2_r   <= v1_r;
      k2_r   <= k1_r;
      n_r    <= n_s;
      prod_r <= prod_s;
      if (iss_act_r) begin
        if (iss_k_r == LAST_K) begin
          iss_act_r <= 1'b0;
        end else begin
          iss_k_r <= iss_k_r + IDX_W'(1);
          addr_r  <= addr_r + TAB_AW'(1);
        end
      end
      if (last_wr_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end
    end
  end

`ifdef CABAC_CTX_SYNC_EN
  logic [6:0] snap_r [CTX_NUM];
  logic       sync_valid_r, restore_s;

  assign restore_s = i_sync_restore && sync_valid_r && !busy_r && !i_init_start;

  // Snapshot capture; a restore in the same cycle leaves the snapshot untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CTX_NUM; i++) snap_r[i] <= 7'd0;
      sync_valid_r <= 1'b0;
    end else if (i_init_start) begin
      sync_valid_r <= 1'b0;
    end else if (i_sync_save && !restore_s) begin
      for (int i = 0; i < CTX_NUM; i++) snap_r[i] <= bank_r[i];
      sync_valid_r <= 1'b1;
    end
  end

  assign o_sync_valid = sync_valid_r;
`else
  logic sync_unused_s;
  assign sync_unused_s = i_sync_save ^ i_sync_restore;
  assign o_sync_valid  = 1'b0;
`endif

  // Bank storage: init writes beat restore, restore beats bin-decoder write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CTX_NUM; i++) bank_r[i] <= 7'd0;
    end else if (!i_init_start) begin
      if (v2_r) begin
        bank_r[k2_r] <= {init_ps_s, init_mps_s};
      end
`ifdef CABAC_CTX_SYNC_EN
      else if (restore_s) begin
        for (int i = 0; i < CTX_NUM; i++) bank_r[i] <= snap_r[i];
      end
`endif
      else if (upd_ok_s) begin
        bank_r[i_upd_idx[IDX_W-1:0]] <= {i_upd_pStateIdx, i_upd_valMps};
      end
    end
  end

  // Combinational read port; out-of-range indices read as zero.
  always_comb begin
    if (rd_ok_s) begin
      {o_pStateIdx, o_valMps} = bank_r[i_rd_idx[IDX_W-1:0]];
    end else begin
      {o_pStateIdx, o_valMps} = 7'd0;
    end
  end

  assign o_init_tab_addr = addr_r;
  assign o_init_done     = done_r;
  assign o_busy          = busy_r;

endmodule

// File: doc/cabac_ctx_bank.md
Name: cabac_ctx_bank

Overview:
- Parametrised CABAC context-variable bank.
- Holds CTX_NUM 7-bit contexts ({pStateIdx[5:0], valMps}) for one syntax-element group, e.g. last_sig_coeff prefix, sig_coeff_flag or greater1_flag.
- Initialises the bank from an external 8-bit initValue table using the HEVC 9.3.2.2 slope/offset derivation, on demand at every slice start.
- Serves a combinational read port and a write-back update port to the bin decoder; optional WPP snapshot save/restore.

Parameters:
CTX_NUM, 36, number of contexts in the bank (1..256)
TAB_AW, 9, init-table address width; must satisfy 2^TAB_AW >= 3*CTX_NUM

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_init_start  in  1  one-cycle pulse, begin (re)initialisation
i_SliceQpY  in  6  slice QP, sampled with i_init_start
i_slice_type  in  2  I/P/B, sampled with i_init_start
i_cabac_init_present_flag  in  1  sampled with i_init_start
i_cabac_init_flag  in  1  sampled with i_init_start
o_init_tab_addr  out  TAB_AW  table address = initType*CTX_NUM + k (registered)
i_init_tab_value  in  8  initValue; valid exactly one cycle after its address
o_init_done  out  1  bank valid and usable
o_busy  out  1  initialisation in progress
i_rd_idx  in  8  read context index
o_pStateIdx  out  6  combinational read data
o_valMps  out  1  combinational read data
i_upd_en  in  1  write-back strobe
i_upd_idx  in  8  write-back index
i_upd_pStateIdx  in  6  new state
i_upd_valMps  in  1  new MPS
i_sync_save  in  1  snapshot bank (CTX_SYNC_EN only)
i_sync_restore  in  1  restore snapshot (CTX_SYNC_EN only)
o_sync_valid  out  1  snapshot holds data (CTX_SYNC_EN only; tied 0 otherwise)

Behaviour:
- Reset:
  - o_init_done=0, o_busy=0, o_init_tab_addr=0, o_sync_valid=0.
  - All bank and snapshot entries = 0, so reads return 0/0.
  - No automatic init after reset.
- initType: 0 when i_slice_type==I; otherwise 2 when present_flag&&init_flag, else 1. Latched at start.
- Init pipeline; T0 = cycle i_init_start is sampled high:
  - T0+1: o_busy=1, o_init_done=0.
  - Address for context k presented in cycle T0+1+k; table value arrives in cycle T0+2+k.
  - Stage 2 registers m=slopeIdx*5-45 and n=(offsetIdx<<3)-16 (slopeIdx=v[7:4], offsetIdx=v[3:0]), plus the signed product m*Clip3(0,51,QP).
  - Context k is written on the edge ending cycle T0+3+k with pre = Clip3(1,126,(prod>>>4)+n). The shift is arithmetic, floor.
  - valMps = (pre>63). pStateIdx = valMps ? pre-64 : 63-pre.
  - o_init_done=1 and o_busy=0 from cycle T0+CTX_NUM+3.
  - Throughput one context/cycle.
  - Width rules: product 14-bit signed, sum 10-bit signed.
- i_init_start while busy: restart from k=0 with newly sampled inputs; partial writes are not rolled back.
- Update/restore while o_busy: i_upd_en and i_sync_restore are ignored.
- Read port: o_pStateIdx/o_valMps = bank[i_rd_idx], combinational. i_rd_idx >= CTX_NUM returns 0/0. While busy, reads return the current, partially initialised contents.
- Update: when i_upd_en && !o_busy && i_upd_idx < CTX_NUM, the entry is written at the clock edge; visible on the read port the next cycle. Out-of-range index is ignored.
- Priority per cycle: rst > i_init_start > busy init writes > i_sync_restore > i_upd_en.
- rst mid-init aborts init and clears everything.

Optional Feature:
CABAC_CTX_SYNC_EN
- Defined:
  - i_sync_save copies the whole bank into the snapshot in one edge and sets o_sync_valid.
  - If i_upd_en is also high that cycle, the snapshot captures the pre-update values.
  - i_sync_restore with o_sync_valid=1 and !o_busy copies snapshot to bank in one edge. Restore without valid snapshot is ignored.
  - Save+restore in the same cycle: restore applied, snapshot unchanged.
  - i_init_start clears o_sync_valid.
- Undefined: snapshot storage absent, sync inputs ignored, o_sync_valid=0.

Test Plan:
1. I-slice, QP=26, table all 63 -> addresses 0..35; every context pStateIdx=8, valMps=0; done at T0+39, busy T0+1..T0+38.
2. P-slice, init_present=1, init_flag=1, initValue=154 everywhere, QP=30 -> addresses 72..107; all contexts pStateIdx=0, valMps=1.
3. initValue=0, QP=51 -> pre clipped to 1, pStateIdx=62, valMps=0. initValue=255, QP=0 -> pre=clip(0+104)=104, pStateIdx=40, valMps=1.
4. Update idx 5 to (17,1), then read idx 5 next cycle -> 17/1. Update idx 40 -> ignored. Update during busy -> ignored. Read idx 200 -> 0/0.
5. Re-pulse i_init_start at T0+10, then rst at T0+20 of the second run -> first run restarts at k=0; rst leaves done=0 and bank zero.
6. (CABAC_CTX_SYNC_EN) Init, save with simultaneous update idx 0 -> snapshot holds the init value. Modify all contexts, then restore -> all init values back, o_sync_valid=1. New init_start -> o_sync_valid=0.
